hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB, branches resolved in ID). Consumes the ID-stage decode hints (`rs1use`, `rs2use`, `hazard_optype`, `Branch`) and keeps its own shadow of the destination register and op class in EX and MEM. From these it drives operand-forwarding selects, load-use stalls, control-flow flushes, and two performance counters.

---
 rtl/hazard_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage RV32I core with
//               branches resolved in ID. Keeps a shadow copy of the
//               destination register and op class held in EX and MEM, and
//               from it derives operand-forwarding selects, load-use stalls,
//               control-flow flushes and stall/flush performance counters.
// Ports       : clk, rst_n              - clock, async active-low reset
//               rs1_ID/rs2_ID/rd_ID     - ID register addresses
//               rs1use_ID/rs2use_ID     - ID operand-use hints
//               hazard_optype_ID        - 00 none, 01 ALU, 10 load, 11 store
//               Branch_ID               - ID redirects the PC
//               PC_EN_IF, reg_FD_EN     - front-end enables (low on stall)
//               reg_FD_flush            - IF/ID flush on redirect
//               reg_DE_flush            - ID/EX bubble on stall
//               forward_ctrl_A/B        - 00 RF, 01 EX ALU, 10 MEM ALU,
//                                         11 MEM load data
//               forward_ctrl_ls         - EX store data from MEM load data
//               stall_cnt, flush_cnt    - wrapping event counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [1:0]       hazard_optype_ID,
    input  logic             Branch_ID,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] c_op_none  = 2'b00;
    localparam logic [1:0] c_op_alu   = 2'b01;
    localparam logic [1:0] c_op_load  = 2'b10;
    localparam logic [1:0] c_op_store = 2'b11;

    localparam logic [1:0] c_fwd_rf       = 2'b00;
    localparam logic [1:0] c_fwd_ex_alu   = 2'b01;
    localparam logic [1:0] c_fwd_mem_alu  = 2'b10;
    localparam logic [1:0] c_fwd_mem_load = 2'b11;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow state of the EX and MEM stages
    logic [4:0]       rd_ex_q,  rd_ex_d;
    logic [1:0]       op_ex_q,  op_ex_d;
    logic             ls_ex_q,  ls_ex_d;
    logic [4:0]       rd_mem_q, rd_mem_d;
    logic [1:0]       op_mem_q, op_mem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Hazard detection
    logic       w_prod_ex;
    logic       w_prod_mem;
    logic       w_a_ex, w_b_ex, w_a_mem, w_b_mem;
    logic       w_a_load_ex, w_b_load_ex;
    logic       w_load_use;
    logic       w_ls_hit;
    logic       w_stall;
    logic       w_fd_flush;

    always_comb begin
        // A stage only produces a forwardable value when it writes a
        // non-zero rd; this also keeps x0 from ever matching.
        w_prod_ex  = (rd_ex_q != 5'd0) &&
                     ((op_ex_q == c_op_alu) || (op_ex_q == c_op_load));
        w_prod_mem = (rd_mem_q != 5'd0) &&
                     ((op_mem_q == c_op_alu) || (op_mem_q == c_op_load));

        w_a_ex  = rs1use_ID && (rs1_ID == rd_ex_q)  && w_prod_ex;
        w_b_ex  = rs2use_ID && (rs2_ID == rd_ex_q)  && w_prod_ex;
        w_a_mem = rs1use_ID && (rs1_ID == rd_mem_q) && w_prod_mem;
        w_b_mem = rs2use_ID && (rs2_ID == rd_mem_q) && w_prod_mem;

        w_a_load_ex = w_a_ex && (op_ex_q == c_op_load);
        w_b_load_ex = w_b_ex && (op_ex_q == c_op_load);
        w_load_use  = w_a_load_ex || w_b_load_ex;

        // A store whose data (rs2) alone comes from the load in EX need not
        // wait: the load value is picked up in EX one cycle later.
        w_ls_hit = (hazard_optype_ID == c_op_store) && w_b_load_ex && !w_a_load_ex;
        w_stall  = w_load_use && !w_ls_hit;

        // Stall suppresses the redirect: the branch operands are not valid
        // yet, so the branch is re-evaluated on the following cycle.
        w_fd_flush = rst_n && Branch_ID && !w_stall;
    end

    // Forward select; youngest producer (EX) takes priority over MEM
    always_comb begin
        forward_ctrl_A = c_fwd_rf;
        if (w_a_ex && (op_ex_q == c_op_alu)) begin
            forward_ctrl_A = c_fwd_ex_alu;
        end else if (w_a_mem && (op_mem_q == c_op_alu)) begin
            forward_ctrl_A = c_fwd_mem_alu;
        end else if (w_a_mem && (op_mem_q == c_op_load)) begin
            forward_ctrl_A = c_fwd_mem_load;
        end

        forward_ctrl_B = c_fwd_rf;
        if (w_b_ex && (op_ex_q == c_op_alu)) begin
            forward_ctrl_B = c_fwd_ex_alu;
        end else if (w_b_mem && (op_mem_q == c_op_alu)) begin
            forward_ctrl_B = c_fwd_mem_alu;
        end else if (w_b_mem && (op_mem_q == c_op_load)) begin
            forward_ctrl_B = c_fwd_mem_load;
        end
    end

    // Next-state: MEM takes EX; EX takes ID unless a bubble is injected
    always_comb begin
        rd_mem_d = rd_ex_q;
        op_mem_d = op_ex_q;
        rd_ex_d  = rd_ID;
        op_ex_d  = hazard_optype_ID;
        ls_ex_d  = w_ls_hit;
        if (w_stall) begin
            rd_ex_d = 5'd0;
            op_ex_d = c_op_none;
            ls_ex_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall) begin
            stall_cnt_d = stall_cnt_q + c_cnt_one;
        end
        if (w_fd_flush) begin
            flush_cnt_d = flush_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ex_q     <= 5'd0;
            op_ex_q     <= c_op_none;
            ls_ex_q     <= 1'b0;
            rd_mem_q    <= 5'd0;
            op_mem_q    <= c_op_none;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            rd_ex_q     <= rd_ex_d;
            op_ex_q     <= op_ex_d;
            ls_ex_q     <= ls_ex_d;
            rd_mem_q    <= rd_mem_d;
            op_mem_q    <= op_mem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_EN_IF        = !w_stall;
    assign reg_FD_EN       = !w_stall;
    assign reg_DE_flush    = w_stall;
    assign reg_FD_flush    = w_fd_flush;
    assign forward_ctrl_ls = ls_ex_q;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;

endmodule
`default_nettype wire
